// File: rtl/sad_accum_min.sv
// sad_accum_min: sums PE row differences into per-candidate SADs and tracks the minimum across a search
module sad_accum_min #(
    parameter int NUM_PE   = 8,
    parameter int PIXEL    = 8,
    parameter int ROWS     = 8,
    parameter int NUM_CAND = 32,
    parameter int SAD_W    = 16,
    parameter int CAND_W   = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [NUM_PE*PIXEL-1:0] abs_in,
    input  logic                    abs_valid,
    output logic                    busy,
    output logic [SAD_W-1:0]        sad_out,
    output logic                    sad_valid,
    output logic [CAND_W-1:0]       sad_idx,
    output logic [SAD_W-1:0]        best_sad,
    output logic [CAND_W-1:0]       best_idx,
    output logic                    done
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;
    state_t            state;
    logic [RW-1:0]     row_cnt;
    logic [CAND_W-1:0] cand_in;
    logic [CAND_W-1:0] cand_cnt;
    logic [SAD_W-1:0]  row_sum;
    logic [SAD_W-1:0]  s1_sum;
    logic [SAD_W-1:0]  acc;
    logic              s1_vld;
    logic              s1_last;
    logic              sad_last;
    logic              take;
    logic              row_last;
    logic              cand_last;
    assign take      = (state == ACCUM) && abs_valid;
    assign row_last  = row_cnt == RW'(ROWS - 1);
    assign cand_last = cand_in == CAND_W'(NUM_CAND - 1);
    // adder tree over the lanes of the incoming row
    always_comb begin
        row_sum = '0;
        for (int i = 0; i < NUM_PE; i++)
            row_sum = row_sum + SAD_W'(abs_in[i*PIXEL +: PIXEL]);
    end
    // control FSM plus stage 1: accept rows, tag the last row of each candidate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            row_cnt <= '0;
            cand_in <= '0;
            s1_vld  <= 1'b0;
            s1_last <= 1'b0;
            s1_sum  <= '0;
        end else if (start) begin
            state   <= ACCUM;
            busy    <= 1'b1;
            done    <= 1'b0;
            row_cnt <= '0;
            cand_in <= '0;
            s1_vld  <= 1'b0;
        end else begin
            done   <= 1'b0;
            s1_vld <= take;
            if (take) begin
                s1_sum  <= row_sum;
                s1_last <= row_last;
                row_cnt <= row_last ? '0 : row_cnt + 1'b1;
                if (row_last) cand_in <= cand_in + 1'b1;
                if (row_last && cand_last) state <= DRAIN;
            end
            if (sad_valid && sad_last) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
            end
        end
    end
    // stage 2: accumulate row sums and publish the candidate SAD on its last row
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            cand_cnt  <= '0;
            sad_out   <= '0;
            sad_idx   <= '0;
            sad_valid <= 1'b0;
            sad_last  <= 1'b0;
        end else if (start) begin
            acc       <= '0;
            cand_cnt  <= '0;
            sad_valid <= 1'b0;
        end else begin
            sad_valid <= s1_vld && s1_last;
            if (s1_vld && s1_last) begin
                sad_out  <= acc + s1_sum;
                sad_idx  <= cand_cnt;
                sad_last <= cand_cnt == CAND_W'(NUM_CAND - 1);
                acc      <= '0;
                cand_cnt <= cand_cnt + 1'b1;
            end else if (s1_vld) begin
                acc <= acc + s1_sum;
            end
        end
    end
    // stage 3: strict-less-than keeps the earliest index on ties
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_sad <= '1;
            best_idx <= '0;
        end else if (start) begin
            best_sad <= '1;
            best_idx <= '0;
        end else if (sad_valid && sad_out < best_sad) begin
            best_sad <= sad_out;
            best_idx <= sad_idx;
        end
    end
endmodule

// File: tb/tb_sad_accum_min.sv
// tb_sad_accum_min: directed searches checked against an event-queue model of sad_accum_min
module tb_sad_accum_min;
    localparam int NC = 32;
    localparam int RS = 8;
    logic        clk = 0;
    logic        rst_n = 1;
    logic        start = 0;
    logic [63:0] abs_in = '0;
    logic        abs_valid = 0;
    logic        busy, sad_valid, done;
    logic [15:0] sad_out, best_sad;
    logic [4:0]  sad_idx, best_idx;
    logic        busy1, sad_valid1, done1;
    logic [15:0] sad_out1, best_sad1;
    logic [4:0]  sad_idx1, best_idx1;
    int checks = 0;
    int errors = 0;

    sad_accum_min dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abs_in(abs_in), .abs_valid(abs_valid),
        .busy(busy), .sad_out(sad_out), .sad_valid(sad_valid), .sad_idx(sad_idx),
        .best_sad(best_sad), .best_idx(best_idx), .done(done)
    );

    sad_accum_min #(.NUM_CAND(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abs_in(abs_in), .abs_valid(abs_valid),
        .busy(busy1), .sad_out(sad_out1), .sad_valid(sad_valid1), .sad_idx(sad_idx1),
        .best_sad(best_sad1), .best_idx(best_idx1), .done(done1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // model: rows are summed as they are accepted; results are scheduled as future events
    typedef struct {int due; bit kind; int sad; int idx; bit fin;} ev_t;
    ev_t q[$];
    int n = 0;
    bit m_act = 0;
    int m_row = 0, m_cand = 0, m_acc = 0;
    logic        e_busy = 0, e_sv = 0, e_done = 0;
    logic [15:0] e_sad = 0, e_best = 16'hffff;
    logic [4:0]  e_sidx = 0, e_bidx = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_act = 0; e_busy = 0; e_sv = 0; e_done = 0;
            e_sad = 0; e_sidx = 0; e_best = 16'hffff; e_bidx = 0;
        end else begin
            n++;
            e_sv = 0;
            e_done = 0;
            if (start) begin
                q.delete();
                m_act = 1; e_busy = 1; m_row = 0; m_cand = 0; m_acc = 0;
                e_best = 16'hffff; e_bidx = 0;
            end else begin
                while (q.size() > 0 && q[0].due == n) begin
                    if (q[0].kind == 0) begin
                        e_sad = 16'(q[0].sad); e_sidx = 5'(q[0].idx); e_sv = 1;
                    end else begin
                        if (q[0].sad < int'(e_best)) begin
                            e_best = 16'(q[0].sad); e_bidx = 5'(q[0].idx);
                        end
                        if (q[0].fin) begin
                            e_done = 1; e_busy = 0;
                        end
                    end
                    void'(q.pop_front());
                end
                if (m_act && abs_valid) begin
                    for (int i = 0; i < 8; i++) m_acc += int'(abs_in[i*8 +: 8]);
                    m_row++;
                    if (m_row == RS) begin
                        q.push_back('{n + 1, 1'b0, m_acc, m_cand, 1'b0});
                        q.push_back('{n + 2, 1'b1, m_acc, m_cand, m_cand == NC - 1});
                        m_cand++; m_row = 0; m_acc = 0;
                        if (m_cand == NC) m_act = 0;
                    end
                end
            end
        end
    end

    int sv_cnt = 0, first_idx = -1, last_idx = -1;

    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(e_busy));
        chk("sad_valid", 32'(sad_valid), 32'(e_sv));
        chk("sad_out", 32'(sad_out), 32'(e_sad));
        chk("sad_idx", 32'(sad_idx), 32'(e_sidx));
        chk("best_sad", 32'(best_sad), 32'(e_best));
        chk("best_idx", 32'(best_idx), 32'(e_bidx));
        chk("done", 32'(done), 32'(e_done));
        if (sad_valid) begin
            if (sv_cnt == 0) first_idx = int'(sad_idx);
            last_idx = int'(sad_idx);
            sv_cnt++;
        end
    end

    function automatic logic [63:0] row_val(input int mode, input int k);
        logic [7:0] x;
        x = (mode == 0) ? 8'd1 : (mode == 1) ? ((k == 13) ? 8'd0 : 8'(k % 7 + 1)) : 8'd255;
        row_val = {8{x}};
        if (mode == 2) row_val = {56'd0, (k == 3 || k == 9) ? 8'd1 : 8'd2};
    endfunction

    task automatic pulse_start();
        start = 1; abs_valid = 1; abs_in = '1;
        sv_cnt = 0; first_idx = -1; last_idx = -1;
        @(negedge clk);
        start = 0; abs_valid = 0;
    endtask

    task automatic feed(input int mode, input int ncand, input bit stall, output int stalls);
        stalls = 0;
        for (int k = 0; k < ncand; k++)
            for (int r = 0; r < RS; r++) begin
                if (stall && $urandom_range(0, 1) == 1) begin
                    abs_valid = 0; abs_in = {$urandom, $urandom}; stalls++;
                    @(negedge clk);
                end
                abs_in = row_val(mode, k); abs_valid = 1;
                @(negedge clk);
            end
        abs_valid = 0;
    endtask

    task automatic wait_done(output int t_done);
        t_done = -1;
        for (int i = 0; i < 3000; i++) begin
            if (done) begin
                t_done = n;
                return;
            end
            @(negedge clk);
        end
        chk("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic search(input int mode, input bit stall, output int lat, output int stalls);
        int t0, t1;
        t0 = n;
        pulse_start();
        feed(mode, NC, stall, stalls);
        wait_done(t1);
        lat = t1 - t0;
    endtask

    initial begin
        int st, lat, lat0;
        #1 rst_n = 0;
        repeat (3) @(negedge clk);
        chk("rst_best_sad", 32'(best_sad), 32'hffff);
        chk("rst_busy", 32'(busy), 32'd0);
        #1 rst_n = 1;
        @(negedge clk);
        // single-candidate instance: all lanes 1
        pulse_start();
        feed(0, 1, 0, st);
        chk("s1_sv_early", 32'(sad_valid1), 32'd0);
        @(negedge clk);
        chk("s1_sv", 32'(sad_valid1), 32'd1);
        chk("s1_sad", 32'(sad_out1), 32'd64);
        chk("s1_idx", 32'(sad_idx1), 32'd0);
        @(negedge clk);
        chk("s1_done", 32'(done1), 32'd1);
        chk("s1_best", 32'(best_sad1), 32'd64);
        chk("s1_bidx", 32'(best_idx1), 32'd0);
        chk("s1_busy", 32'(busy1), 32'd0);
        // candidate 13 is zero
        search(1, 0, lat, st);
        chk("s2_lat", 32'(lat), 32'd259);
        chk("s2_best", 32'(best_sad), 32'd0);
        chk("s2_bidx", 32'(best_idx), 32'd13);
        chk("s2_count", 32'(sv_cnt), 32'd32);
        chk("s2_first", 32'(first_idx), 32'd0);
        chk("s2_last", 32'(last_idx), 32'd31);
        // tie at SAD 8 between candidates 3 and 9
        search(2, 0, lat, st);
        chk("s3_best", 32'(best_sad), 32'd8);
        chk("s3_bidx", 32'(best_idx), 32'd3);
        // saturated lanes
        search(3, 0, lat0, st);
        chk("s4_best", 32'(best_sad), 32'd16320);
        chk("s4_bidx", 32'(best_idx), 32'd0);
        // same with random stalls
        search(3, 1, lat, st);
        chk("s5_lat", 32'(lat), 32'(lat0 + st));
        chk("s5_best", 32'(best_sad), 32'd16320);
        chk("s5_bidx", 32'(best_idx), 32'd0);
        // abort after 5 candidates, restart immediately after the last row
        pulse_start();
        feed(1, 5, 0, st);
        search(1, 0, lat, st);
        chk("s6_lat", 32'(lat), 32'd259);
        chk("s6_count", 32'(sv_cnt), 32'd32);
        chk("s6_first", 32'(first_idx), 32'd0);
        chk("s6_bidx", 32'(best_idx), 32'd13);
        // reset mid-search while a SAD is in flight
        pulse_start();
        feed(0, 2, 0, st);
        #1 rst_n = 0;
        @(negedge clk);
        chk("s7_busy", 32'(busy), 32'd0);
        chk("s7_sv", 32'(sad_valid), 32'd0);
        chk("s7_best", 32'(best_sad), 32'hffff);
        chk("s7_sad", 32'(sad_out), 32'd0);
        #1 rst_n = 1;
        sv_cnt = 0;
        repeat (10) @(negedge clk);
        chk("s7_no_sv", 32'(sv_cnt), 32'd0);
        chk("s7_idle", 32'(busy), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sad_accum_min.md
# sad_accum_min

Downstream consumer of the PE array in the integer motion-estimation datapath. Each cycle it sums the `abs_out` values of one PE row (NUM_PE lanes), accumulates ROWS such row sums into the SAD of one candidate position, and compares candidates to track the minimum SAD and its candidate index across a search of NUM_CAND candidates. It emits a per-candidate SAD stream and a final best-match result to the MV decision logic.

## Interface
- NUM_PE, 8, lanes (PE absolute-difference outputs) per row
- PIXEL, 8, bits per absolute difference
- ROWS, 8, valid rows accumulated per candidate
- NUM_CAND, 32, candidates per search
- SAD_W, 16, SAD width; must hold NUM_PE*ROWS*(2^PIXEL-1)
- CAND_W, 5, candidate index width; must satisfy 2^CAND_W >= NUM_CAND
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; begins a new search (aborts any search in progress)
- abs_in  in  NUM_PE*PIXEL  packed lane differences, lane i at bits [i*PIXEL +: PIXEL]
- abs_valid  in  1  abs_in holds one valid row
- busy  out  1  search in progress
- sad_out  out  SAD_W  SAD of the most recently completed candidate
- sad_valid  out  1  one-cycle pulse, sad_out updated
- sad_idx  out  CAND_W  candidate index of sad_out
- best_sad  out  SAD_W  running minimum SAD
- best_idx  out  CAND_W  candidate index of best_sad
- done  out  1  one-cycle pulse, search complete, best_* final

## Operation
- FSM states: IDLE, ACCUM, DRAIN.
- IDLE: abs_valid ignored. start -> ACCUM; row_cnt=0, cand_cnt=0, accumulator=0, best_sad=all ones, best_idx=0, busy=1.
- ACCUM: on abs_valid, register row sum (unsigned sum of NUM_PE lanes, zero-extended to SAD_W) = pipeline stage 1; row_cnt increments, wrapping ROWS-1 -> 0 and tagging that row as last-of-candidate. abs_valid may drop at any cycle (stall); the counters hold.
- Stage 2: add the registered row sum to the accumulator. On a last-tagged row: sad_out = accumulator + row sum, sad_idx = cand_cnt, sad_valid pulse, accumulator cleared, cand_cnt++.
- After the last row of candidate NUM_CAND-1 enters stage 1: ACCUM -> DRAIN; further abs_valid ignored.
- Stage 3: on sad_valid, if sad_out < best_sad (strictly), best_sad=sad_out, best_idx=sad_idx. Ties keep the earlier index.
- DRAIN: when stage 3 processes the final candidate: done pulse, busy=0 -> IDLE. best_* hold until the next start.
- start in any state: restart as in IDLE. In-flight pipeline data is discarded (its valid tags are cleared). An abs_valid in the same cycle as start is dropped.
- Arithmetic is unsigned with no saturation. SAD_W sizing guarantees no overflow.

## Timing
- Reset values: busy=0, sad_out=0, sad_valid=0, sad_idx=0, best_sad=all ones, best_idx=0, done=0. All internal counters and valid tags are 0, FSM=IDLE.
- start sampled at edge E -> busy=1 after E. The first abs_valid counted is at E+1.
- Last row of a candidate sampled at edge E0 -> sad_valid/sad_out/sad_idx after E0+1 -> best_* updated after E0+2.
- For the final candidate, done is high for the cycle after E0+2, coincident with final best_*. busy falls at the same edge.
- With no stalls, one full search = NUM_CAND*ROWS valid cycles + 3 cycles to done.
- Back-to-back candidates: sad_valid can pulse every ROWS cycles. Stage 3 accepts one SAD per cycle, so there is no backpressure.
- Reset asserted mid-search: all outputs return to reset values immediately (asynchronous). No done is produced.

## Test plan
- All lanes=1, 8 valid rows, single candidate (NUM_CAND=1 override) -> sad_out=64, sad_valid 2 cycles after last row, done 1 cycle later, best_sad=64, best_idx=0.
- 32 candidates, candidate k lanes = (k==13) ? 0 : k%7+1 -> best_idx=13, best_sad=0, exactly 32 sad_valid pulses with sad_idx 0..31.
- Candidates 3 and 9 both SAD=8 (lane 0=1 per row, rest 0), all others larger -> best_idx=3, best_sad=8.
- All lanes=255 for all rows -> every sad_out=16320, no wrap. best_idx=0.
- Random abs_valid gaps (50% duty) during the previous scenario -> identical sad_out/best results, done delayed only by stall count.
- start asserted after 5 candidates, then a fresh 32-candidate search -> no sad_valid carries over from the aborted search, sad_idx restarts at 0. Separately, rst_n low mid-search -> all outputs at reset values, no done.
